// File: rtl/alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl
// Purpose  : Multi-cycle sequencer for one ARM-style data-processing request:
//            operand fetch, ALU execute, result/NZCV commit, done report.
// Revision : 1.0  initial release
// ============================================================================
module alu_ctrl #(
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_cond,
    input  logic [3:0]        req_cmd,
    input  logic              req_s,
    input  logic [REG_AW-1:0] req_rn,
    input  logic [REG_AW-1:0] req_rm,
    input  logic [REG_AW-1:0] req_rd,
    output logic [REG_AW-1:0] rf_raddr,
    input  logic [31:0]       rf_rdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [3:0]        alu_cmd,
    output logic [1:0]        alu_op,
    input  logic [31:0]       alu_out,
    input  logic [3:0]        alu_flags,
    output logic [3:0]        flags_q,
    output logic              done,
    output logic              skipped,
    output logic              err
);

    localparam logic [3:0] c_cmd_and = 4'd0;
    localparam logic [3:0] c_cmd_xor = 4'd1;
    localparam logic [3:0] c_cmd_sub = 4'd2;
    localparam logic [3:0] c_cmd_rsb = 4'd3;
    localparam logic [3:0] c_cmd_add = 4'd4;
    localparam logic [3:0] c_cmd_cmp = 4'd10;
    localparam logic [3:0] c_cmd_orr = 4'd12;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_EXEC = 3'd3,
        ST_WB   = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cmd;
    logic              r_s;
    logic [REG_AW-1:0] r_rn;
    logic [REG_AW-1:0] r_rm;
    logic [REG_AW-1:0] r_rd;
    logic [31:0]       r_opa;
    logic [31:0]       r_opb;
    logic [31:0]       r_result;
    logic [3:0]        r_flags;
    logic              r_skip;
    logic              r_err;
    logic              w_cmd_ok;
    logic              w_cond_ok;

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'd0:    cond_pass = z;
            4'd1:    cond_pass = !z;
            4'd2:    cond_pass = c;
            4'd3:    cond_pass = !c;
            4'd4:    cond_pass = n;
            4'd5:    cond_pass = !n;
            4'd6:    cond_pass = v;
            4'd7:    cond_pass = !v;
            4'd8:    cond_pass = c && !z;
            4'd9:    cond_pass = !c || z;
            4'd10:   cond_pass = (n == v);
            4'd11:   cond_pass = (n != v);
            4'd12:   cond_pass = !z && (n == v);
            4'd13:   cond_pass = z || (n != v);
            4'd14:   cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    always_comb begin
        w_cmd_ok = 1'b0;
        case (req_cmd)
            c_cmd_and, c_cmd_xor, c_cmd_sub, c_cmd_rsb,
            c_cmd_add, c_cmd_cmp, c_cmd_orr: w_cmd_ok = 1'b1;
            default:                         w_cmd_ok = 1'b0;
        endcase
    end

    assign w_cond_ok = cond_pass(req_cond, r_flags);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cmd    <= '0;
            r_s      <= 1'b0;
            r_rn     <= '0;
            r_rm     <= '0;
            r_rd     <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_skip   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_cmd  <= req_cmd;
                        r_s    <= req_s;
                        r_rn   <= req_rn;
                        r_rm   <= req_rm;
                        r_rd   <= req_rd;
                        r_err  <= !w_cmd_ok;
                        r_skip <= w_cmd_ok && !w_cond_ok;
                    end
                end
                ST_RD_B: r_opa <= rf_rdata;
                ST_EXEC: begin
                    r_opb    <= rf_rdata;
                    r_result <= alu_out;
                    if (r_s || (r_cmd == c_cmd_cmp)) begin
                        r_flags <= alu_flags;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rf_raddr  = '0;
        rf_we     = 1'b0;
        done      = 1'b0;
        skipped   = 1'b0;
        err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = (w_cmd_ok && w_cond_ok) ? ST_RD_A : ST_FIN;
                end
            end
            ST_RD_A: begin
                rf_raddr = r_rn;
                w_next   = ST_RD_B;
            end
            ST_RD_B: begin
                rf_raddr = r_rm;
                w_next   = ST_EXEC;
            end
            ST_EXEC: w_next = ST_WB;
            ST_WB: begin
                rf_we  = (r_cmd != c_cmd_cmp);
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            ST_FIN: begin
                done    = 1'b1;
                skipped = r_skip;
                err     = r_err;
                w_next  = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand B arrives from the register file during EXEC itself, so the ALU
    // sees it directly that cycle; afterwards the captured copy holds it stable.
    assign alu_b    = (r_state == ST_EXEC) ? rf_rdata : r_opb;
    assign alu_a    = r_opa;
    assign alu_cmd  = r_cmd;
    assign alu_op   = 2'b00;
    assign rf_waddr = r_rd;
    assign rf_wdata = r_result;
    assign flags_q  = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_ctrl
// Purpose  : Self-checking bench for alu_ctrl with register-file/ALU models.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_ctrl;

    localparam int REG_AW = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [3:0]        req_cond = '0;
    logic [3:0]        req_cmd = '0;
    logic              req_s = 1'b0;
    logic [REG_AW-1:0] req_rn = '0;
    logic [REG_AW-1:0] req_rm = '0;
    logic [REG_AW-1:0] req_rd = '0;
    logic [REG_AW-1:0] rf_raddr;
    logic [31:0]       rf_rdata = '0;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [31:0]       rf_wdata;
    logic [31:0]       alu_a;
    logic [31:0]       alu_b;
    logic [3:0]        alu_cmd;
    logic [1:0]        alu_op;
    logic [31:0]       alu_out;
    logic [3:0]        alu_flags;
    logic [3:0]        flags_q;
    logic              done;
    logic              skipped;
    logic              err;

    always #5 clk = ~clk;

    alu_ctrl #(.REG_AW(REG_AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cond(req_cond), .req_cmd(req_cmd), .req_s(req_s),
        .req_rn(req_rn), .req_rm(req_rm), .req_rd(req_rd),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_op(alu_op),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .flags_q(flags_q), .done(done), .skipped(skipped), .err(err)
    );

    // Register file: synchronous read, plus a two-slot preload port for stimulus.
    logic [31:0]       rf [16];
    logic              pl_en = 1'b0;
    logic [REG_AW-1:0] pl_a = '0;
    logic [REG_AW-1:0] pl_b = '0;
    logic [31:0]       pl_da = '0;
    logic [31:0]       pl_db = '0;

    always @(posedge clk) begin
        rf_rdata <= rf[rf_raddr];
        if (rf_we) rf[rf_waddr] <= rf_wdata;
        if (pl_en) begin
            rf[pl_a] <= pl_da;
            rf[pl_b] <= pl_db;
        end
    end

    always_comb begin : b_alu
        logic [32:0] t;
        logic        c;
        logic        v;
        t = '0;
        c = 1'b0;
        v = 1'b0;
        alu_out = '0;
        case (alu_cmd)
            4'd0:  alu_out = alu_a & alu_b;
            4'd1:  alu_out = alu_a ^ alu_b;
            4'd12: alu_out = alu_a | alu_b;
            4'd2, 4'd10: begin
                t = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_out = t[31:0];
                c = t[32];
                v = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
            end
            4'd3: begin
                t = {1'b0, alu_b} + {1'b0, ~alu_a} + 33'd1;
                alu_out = t[31:0];
                c = t[32];
                v = (alu_b[31] != alu_a[31]) && (alu_out[31] != alu_b[31]);
            end
            4'd4: begin
                t = {1'b0, alu_a} + {1'b0, alu_b};
                alu_out = t[31:0];
                c = t[32];
                v = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
            end
            default: alu_out = '0;
        endcase
        alu_flags = {alu_out[31], (alu_out == 32'd0), c, v};
    end

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  cond;
        logic [3:0]  cmd;
        logic        s;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [3:0]  rd;
        logic [31:0] va;
        logic [31:0] vb;
        logic [1:0]  kind;   // 0 executed, 1 skipped, 2 error
        logic        we;
        logic [31:0] res;
        logic [3:0]  flags;
    } vec_t;

    typedef struct {
        logic        we;
        logic [3:0]  rd;
        logic [31:0] res;
        logic        skip;
        logic        err;
        logic [3:0]  flags;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    function automatic vec_t mk(input logic [3:0] cond, input logic [3:0] cmd, input logic s,
                                input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                                input logic [31:0] va, input logic [31:0] vb, input logic [1:0] kind,
                                input logic we, input logic [31:0] res, input logic [3:0] flags);
        vec_t v;
        v.cond = cond; v.cmd = cmd; v.s = s; v.rn = rn; v.rm = rm; v.rd = rd;
        v.va = va; v.vb = vb; v.kind = kind; v.we = we; v.res = res; v.flags = flags;
        return v;
    endfunction

    function automatic exp_t mkexp(input vec_t v, input int acc);
        exp_t e;
        e.we = v.we; e.rd = v.rd; e.res = v.res; e.flags = v.flags;
        e.skip = (v.kind == 2'd1);
        e.err = (v.kind == 2'd2);
        e.acc = acc;
        e.lat = (v.kind == 2'd0) ? 4 : 1;
        return e;
    endfunction

    // Scoreboard consumer: every done pulse retires the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                chk("sb_pending", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                    chk("skipped", 32'(skipped), 32'(e.skip));
                    chk("err", 32'(err), 32'(e.err));
                    chk("flags_q", 32'(flags_q), 32'(e.flags));
                    chk("rf_we", 32'(rf_we), 32'(e.we));
                    chk("rf_raddr_done", 32'(rf_raddr), 32'd0);
                    if (e.we) begin
                        chk("rf_waddr", 32'(rf_waddr), 32'(e.rd));
                        chk("rf_wdata", rf_wdata, e.res);
                    end
                end
            end else begin
                chk("quiet_when_idle", {29'd0, rf_we, skipped, err}, 32'd0);
            end
        end
    end

    task automatic wait_ready(output int acc);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept", 32'(req_ready), 32'd1);
        acc = cyc;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic send(input vec_t v);
        int acc;
        @(negedge clk);
        pl_en = 1'b1; pl_a = v.rn; pl_da = v.va; pl_b = v.rm; pl_db = v.vb;
        req_cond = v.cond; req_cmd = v.cmd; req_s = v.s;
        req_rn = v.rn; req_rm = v.rm; req_rd = v.rd;
        req_valid = 1'b1;
        wait_ready(acc);
        sb.push_back(mkexp(v, acc));
        @(negedge clk);
        req_valid = 1'b0;
        pl_en = 1'b0;
        drain();
    endtask

    vec_t vecs[23];

    initial begin
        int   acc1;
        int   acc2;
        vec_t v;

        for (int i = 0; i < 16; i++) rf[i] = 32'd0;

        //            cond   cmd    s     rn    rm    rd    va            vb            kind  we    res           flags
        vecs[0]  = mk(4'd14, 4'd4,  1'b1, 4'd1, 4'd2, 4'd5, 32'h7FFFFFFF, 32'd1,        2'd0, 1'b1, 32'h80000000, 4'b1001);
        vecs[1]  = mk(4'd0,  4'd2,  1'b1, 4'd7, 4'd8, 4'd9, 32'd9,        32'd1,        2'd1, 1'b0, 32'd0,        4'b1001);
        vecs[2]  = mk(4'd15, 4'd2,  1'b1, 4'd7, 4'd8, 4'd9, 32'd9,        32'd1,        2'd1, 1'b0, 32'd0,        4'b1001);
        vecs[3]  = mk(4'd14, 4'd5,  1'b1, 4'd7, 4'd8, 4'd9, 32'd9,        32'd1,        2'd2, 1'b0, 32'd0,        4'b1001);
        vecs[4]  = mk(4'd14, 4'd3,  1'b0, 4'd2, 4'd3, 4'd7, 32'd3,        32'd10,       2'd0, 1'b1, 32'd7,        4'b1001);
        vecs[5]  = mk(4'd14, 4'd10, 1'b0, 4'd3, 4'd4, 4'd6, 32'd5,        32'd5,        2'd0, 1'b0, 32'd0,        4'b0110);
        vecs[6]  = mk(4'd1,  4'd4,  1'b1, 4'd1, 4'd2, 4'd8, 32'd1,        32'd1,        2'd1, 1'b0, 32'd0,        4'b0110);
        vecs[7]  = mk(4'd0,  4'd4,  1'b0, 4'd1, 4'd2, 4'd8, 32'd10,       32'd20,       2'd0, 1'b1, 32'd30,       4'b0110);
        vecs[8]  = mk(4'd15, 4'd15, 1'b1, 4'd1, 4'd2, 4'd8, 32'd10,       32'd20,       2'd2, 1'b0, 32'd0,        4'b0110);
        vecs[9]  = mk(4'd2,  4'd2,  1'b1, 4'd1, 4'd2, 4'd9, 32'd3,        32'd5,        2'd0, 1'b1, 32'hFFFFFFFE, 4'b1000);
        vecs[10] = mk(4'd8,  4'd4,  1'b1, 4'd1, 4'd2, 4'd9, 32'd3,        32'd5,        2'd1, 1'b0, 32'd0,        4'b1000);
        vecs[11] = mk(4'd10, 4'd0,  1'b1, 4'd1, 4'd2, 4'd9, 32'd3,        32'd5,        2'd1, 1'b0, 32'd0,        4'b1000);
        vecs[12] = mk(4'd11, 4'd1,  1'b1, 4'd4, 4'd5, 4'd10, 32'hF0F0F0F0, 32'h0F0F0F0F, 2'd0, 1'b1, 32'hFFFFFFFF, 4'b1000);
        vecs[13] = mk(4'd14, 4'd0,  1'b1, 4'd4, 4'd5, 4'd11, 32'h000000F0, 32'h0000000F, 2'd0, 1'b1, 32'd0,       4'b0100);
        vecs[14] = mk(4'd0,  4'd12, 1'b0, 4'd4, 4'd5, 4'd12, 32'h000000F0, 32'h0000000F, 2'd0, 1'b1, 32'h000000FF, 4'b0100);
        vecs[15] = mk(4'd13, 4'd4,  1'b1, 4'd1, 4'd2, 4'd13, 32'hFFFFFFFF, 32'd1,       2'd0, 1'b1, 32'd0,        4'b0110);
        vecs[16] = mk(4'd12, 4'd4,  1'b1, 4'd1, 4'd2, 4'd13, 32'd1,       32'd1,        2'd1, 1'b0, 32'd0,        4'b0110);
        vecs[17] = mk(4'd14, 4'd10, 1'b0, 4'd1, 4'd2, 4'd14, 32'd3,       32'd5,        2'd0, 1'b0, 32'd0,        4'b1000);
        vecs[18] = mk(4'd4,  4'd4,  1'b0, 4'd1, 4'd2, 4'd14, 32'd2,       32'd2,        2'd0, 1'b1, 32'd4,        4'b1000);
        vecs[19] = mk(4'd5,  4'd4,  1'b0, 4'd1, 4'd2, 4'd14, 32'd2,       32'd2,        2'd1, 1'b0, 32'd0,        4'b1000);
        vecs[20] = mk(4'd7,  4'd4,  1'b0, 4'd6, 4'd6, 4'd6, 32'd21,       32'd21,       2'd0, 1'b1, 32'd42,       4'b1000);
        vecs[21] = mk(4'd6,  4'd4,  1'b0, 4'd1, 4'd2, 4'd15, 32'd1,       32'd2,        2'd1, 1'b0, 32'd0,        4'b1000);
        vecs[22] = mk(4'd3,  4'd4,  1'b0, 4'd1, 4'd2, 4'd15, 32'd1,       32'd2,        2'd0, 1'b1, 32'd3,        4'b1000);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_done_flags", {28'd0, done, skipped, err, rf_we}, 32'd0);
        chk("rst_raddr_waddr", {24'd0, rf_raddr, rf_waddr}, 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_cmd_op", {26'd0, alu_cmd, alu_op}, 32'd0);
        chk("rst_flags_q", 32'(flags_q), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            send(vecs[i]);
            if (vecs[i].we) chk("rf_commit", rf[vecs[i].rd], vecs[i].res);
        end

        // Back-to-back: req_valid held; second reads the first's result twice.
        @(negedge clk);
        pl_en = 1'b1; pl_a = 4'd1; pl_da = 32'd100; pl_b = 4'd2; pl_db = 32'd5;
        req_cond = 4'd14; req_cmd = 4'd4; req_s = 1'b0;
        req_rn = 4'd1; req_rm = 4'd2; req_rd = 4'd3; req_valid = 1'b1;
        wait_ready(acc1);
        v = mk(4'd14, 4'd4, 1'b0, 4'd1, 4'd2, 4'd3, 32'd100, 32'd5, 2'd0, 1'b1, 32'd105, 4'b1000);
        sb.push_back(mkexp(v, acc1));
        @(negedge clk);
        pl_en = 1'b0;
        req_rn = 4'd3; req_rm = 4'd3; req_rd = 4'd5;
        wait_ready(acc2);
        chk("b2b_gap", 32'(acc2 - acc1), 32'd5);
        v = mk(4'd14, 4'd4, 1'b0, 4'd3, 4'd3, 4'd5, 32'd0, 32'd0, 2'd0, 1'b1, 32'd210, 4'b1000);
        sb.push_back(mkexp(v, acc2));
        @(negedge clk);
        req_valid = 1'b0;
        drain();
        chk("b2b_r5", rf[5], 32'd210);

        // Reset asserted during EXEC of an ADD s=1.
        @(negedge clk);
        pl_en = 1'b1; pl_a = 4'd1; pl_da = 32'h7FFFFFFF; pl_b = 4'd2; pl_db = 32'd1;
        req_cond = 4'd14; req_cmd = 4'd4; req_s = 1'b1;
        req_rn = 4'd1; req_rm = 4'd2; req_rd = 4'd6; req_valid = 1'b1;
        wait_ready(acc1);
        @(negedge clk);
        pl_en = 1'b0;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(req_ready), 32'd1);
        chk("midrst_flags", 32'(flags_q), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_we", 32'(rf_we), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_flags", 32'(flags_q), 32'd0);
        chk("post_rst_done", 32'(done), 32'd0);
        chk("r6_kept", rf[6], 32'd42);

        send(mk(4'd14, 4'd4, 1'b0, 4'd1, 4'd2, 4'd15, 32'd40, 32'd2, 2'd0, 1'b1, 32'd42, 4'b0000));
        chk("recover_r15", rf[15], 32'd42);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
